// File: rtl/vga_write_fifo_if.sv
// rtl/vga_write_fifo_if.sv - host/status/VGA-port bundle for the VGA write-posting FIFO
//
// Purpose: groups the host write port, the status flags and the memory
// controller VGA write port of vga_write_fifo into one interface.
// Ports (signals):
//   hostWr, hostAddr, hostData   host write strobe, address and data
//   overflowClr                  clears the sticky overflow flag
//   full, empty, level           occupancy status
//   overflow                     sticky dropped-push flag
//   busy                         drain FSM not idle
//   wrVga, aVga, dVga            one-clock write pulse, address and data to the controller
//   wrVgaReq                     controller acknowledge (last tick of its write cycle)
// Modports: slave = the FIFO, master = the host/controller side.

interface vga_write_fifo_if #(
    parameter int DEPTH_LOG2 = 3,
    parameter int AW         = 16,
    parameter int DW         = 8
);
    logic                  hostWr;
    logic [AW-1:0]         hostAddr;
    logic [DW-1:0]         hostData;
    logic                  overflowClr;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;
    logic                  busy;
    logic                  wrVga;
    logic [AW-1:0]         aVga;
    logic [DW-1:0]         dVga;
    logic                  wrVgaReq;

    modport slave (
        input  hostWr, hostAddr, hostData, overflowClr, wrVgaReq,
        output full, empty, level, overflow, busy, wrVga, aVga, dVga
    );

    modport master (
        output hostWr, hostAddr, hostData, overflowClr, wrVgaReq,
        input  full, empty, level, overflow, busy, wrVga, aVga, dVga
    );
endinterface

// File: rtl/vga_write_fifo.sv
// rtl/vga_write_fifo.sv - write-posting FIFO from host bus to memory controller VGA write port
//
// Purpose: buffers host writes so the host never waits for the memory slot,
// then drains them in order as single-clock wrVga pulses, holding aVga/dVga
// until the controller acknowledges with wrVgaReq.
// Ports:
//   clk      system clock
//   reset    asynchronous, active-high reset
//   fifo_if  vga_write_fifo_if.slave (host port, status, VGA write port)
// Build option: HOST_SYNC_EN - hostWr is asynchronous; it is synchronised
//   (2 flops) and rising-edge detected, one push per rising edge.

module vga_write_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int AW         = 16,
    parameter int DW         = 8
) (
    input  logic             clk,
    input  logic             reset,
    vga_write_fifo_if.slave  fifo_if
);
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    logic [AW+DW-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic             overflow_q, overflow_d;
    logic [PW-1:0]    level;
    logic             full, empty;
    logic             push_req, push_ok, pop;

    state_t           state_q;
    logic             wr_vga_q;
    logic [AW-1:0]    a_vga_q;
    logic [DW-1:0]    d_vga_q;

`ifdef HOST_SYNC_EN
    logic [1:0] sync_q;
    logic       prev_q;

    // sync_q[1] is the first clean copy; a push fires on the edge where it is
    // high and its delayed copy is still low, i.e. the third edge after the rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], fifo_if.hostWr};
            prev_q <= sync_q[1];
        end
    end

    assign push_req = sync_q[1] & ~prev_q;
`else
    assign push_req = fifo_if.hostWr;
`endif

    // Pointer difference counts the in-flight entry: rptr only advances on ack.
    assign level   = wptr_q - rptr_q;
    assign full    = (level == DEPTH_L);
    assign empty   = (level == '0);
    assign push_ok = push_req & ~full;
    assign pop     = (state_q == ST_WAIT) & fifo_if.wrVgaReq;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        // A dropped push beats a simultaneous clear.
        if (push_req && full) begin
            overflow_d = 1'b1;
        end else if (fifo_if.overflowClr) begin
            overflow_d = 1'b0;
        end
    end

    // Storage needs no reset: pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q[DEPTH_LOG2-1:0]] <= {fifo_if.hostAddr, fifo_if.hostData};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Drain FSM. wrVga drops in ISSUE so the controller never sees it across
    // the end of its write cycle; aVga/dVga stay put until the ack edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_vga_q <= 1'b0;
            a_vga_q  <= '0;
            d_vga_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty) begin
                        {a_vga_q, d_vga_q} <= mem_q[rptr_q[DEPTH_LOG2-1:0]];
                        wr_vga_q           <= 1'b1;
                        state_q            <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wr_vga_q <= 1'b0;
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (fifo_if.wrVgaReq) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    wr_vga_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_if.full     = full;
    assign fifo_if.empty    = empty;
    assign fifo_if.level    = level;
    assign fifo_if.overflow = overflow_q;
    assign fifo_if.busy     = (state_q != ST_IDLE);
    assign fifo_if.wrVga    = wr_vga_q;
    assign fifo_if.aVga     = a_vga_q;
    assign fifo_if.dVga     = d_vga_q;
endmodule

// File: tb/tb_vga_write_fifo.sv
// tb/tb_vga_write_fifo.sv - directed self-checking bench for vga_write_fifo

module tb_vga_write_fifo;
    logic clk = 1'b0;
    logic reset = 1'b1;

    vga_write_fifo_if #(.DEPTH_LOG2(3), .AW(16), .DW(8)) bus ();

    vga_write_fifo #(.DEPTH_LOG2(3), .AW(16), .DW(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .fifo_if (bus)
    );

    always #20 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    logic manual_req = 1'b0;
    logic model_req  = 1'b0;
    logic model_en   = 1'b0;
    assign bus.wrVgaReq = manual_req | model_req;

    int pulse_cnt = 0;
    int stab_err  = 0;
    logic [15:0] wr_addr [$];
    logic [7:0]  wr_data [$];

    always @(posedge clk) begin
        if (bus.wrVga) pulse_cnt <= pulse_cnt + 1;
    end

    // Controller model: acknowledge on the fourth tick after the pulse, and
    // confirm the address/data did not move across the write slot.
    initial begin
        logic [15:0] a0;
        logic [7:0]  d0;
        forever begin
            @(negedge clk);
            model_req = 1'b0;
            if (model_en && bus.wrVga) begin
                a0 = bus.aVga;
                d0 = bus.dVga;
                repeat (3) @(negedge clk);
                if (bus.aVga !== a0 || bus.dVga !== d0) stab_err++;
                wr_addr.push_back(a0);
                wr_data.push_back(d0);
                model_req = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] a, input logic [7:0] d);
        bus.hostWr   = 1'b1;
        bus.hostAddr = a;
        bus.hostData = d;
        tick();
        bus.hostWr   = 1'b0;
    endtask

    // Wait for the WAIT state (busy, pulse already gone), check head, acknowledge.
    task automatic ack_expect(input string tag, input logic [15:0] a, input logic [7:0] d);
        int n = 0;
        while (!(bus.busy && !bus.wrVga) && n < 12) begin
            tick();
            n++;
        end
        check({tag, " timeout"}, 32'(n < 12), 32'd1);
        check({tag, " aVga"}, 32'(bus.aVga), 32'(a));
        check({tag, " dVga"}, 32'(bus.dVga), 32'(d));
        manual_req = 1'b1;
        tick();
        manual_req = 1'b0;
    endtask

    initial begin
        int base;
        bus.hostWr      = 1'b0;
        bus.hostAddr    = '0;
        bus.hostData    = '0;
        bus.overflowClr = 1'b0;
        repeat (3) tick();
        check("rst level", 32'(bus.level), 32'd0);
        check("rst empty", 32'(bus.empty), 32'd1);
        check("rst full", 32'(bus.full), 32'd0);
        check("rst overflow", 32'(bus.overflow), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst wrVga", 32'(bus.wrVga), 32'd0);
        check("rst aVga", 32'(bus.aVga), 32'd0);
        check("rst dVga", 32'(bus.dVga), 32'd0);
        reset = 1'b0;
        tick();

`ifdef HOST_SYNC_EN
        model_en = 1'b1;
        base = pulse_cnt;
        bus.hostAddr = 16'h4000;
        bus.hostData = 8'hA5;
        bus.hostWr   = 1'b1;
        tick();
        tick();
        check("sync level edge2", 32'(bus.level), 32'd0);
        tick();
        check("sync level edge3", 32'(bus.level), 32'd1);
        repeat (7) tick();
        bus.hostWr = 1'b0;
        repeat (12) tick();
        check("sync writes", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() > 0) begin
            check("sync addr", 32'(wr_addr[0]), 32'h4000);
            check("sync data", 32'(wr_data[0]), 32'hA5);
        end
        check("sync pulses", 32'(pulse_cnt - base), 32'd1);
        check("sync empty", 32'(bus.empty), 32'd1);
        check("sync stable", 32'(stab_err), 32'd0);
`else
        // Single write, manual acknowledge.
        base = pulse_cnt;
        push(16'h1234, 8'h5A);
        check("sw level", 32'(bus.level), 32'd1);
        check("sw wrVga E0", 32'(bus.wrVga), 32'd0);
        tick();
        check("sw wrVga E1", 32'(bus.wrVga), 32'd1);
        check("sw aVga E1", 32'(bus.aVga), 32'h1234);
        check("sw dVga E1", 32'(bus.dVga), 32'h5A);
        tick();
        check("sw wrVga E2", 32'(bus.wrVga), 32'd0);
        repeat (3) tick();
        check("sw aVga hold", 32'(bus.aVga), 32'h1234);
        check("sw dVga hold", 32'(bus.dVga), 32'h5A);
        check("sw level hold", 32'(bus.level), 32'd1);
        manual_req = 1'b1;
        tick();
        manual_req = 1'b0;
        check("sw ack empty", 32'(bus.empty), 32'd1);
        check("sw ack busy", 32'(bus.busy), 32'd0);
        repeat (4) tick();
        check("sw pulses", 32'(pulse_cnt - base), 32'd1);

        // Overflow: 9 back-to-back pushes, no acknowledge.
        for (int i = 0; i < 9; i++) begin
            bus.hostWr   = 1'b1;
            bus.hostAddr = 16'h0100 + 16'(i);
            bus.hostData = 8'h10 + 8'(i);
            tick();
        end
        bus.hostWr = 1'b0;
        check("ovf level", 32'(bus.level), 32'd8);
        check("ovf full", 32'(bus.full), 32'd1);
        check("ovf flag", 32'(bus.overflow), 32'd1);
        bus.hostWr      = 1'b1;
        bus.hostAddr    = 16'hDEAD;
        bus.overflowClr = 1'b1;
        tick();
        bus.hostWr = 1'b0;
        check("ovf set wins", 32'(bus.overflow), 32'd1);
        check("ovf level after drop", 32'(bus.level), 32'd8);
        tick();
        bus.overflowClr = 1'b0;
        check("ovf cleared", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 8; i++) begin
            ack_expect($sformatf("ovf drain%0d", i), 16'h0100 + 16'(i), 8'h10 + 8'(i));
        end
        repeat (4) tick();
        check("ovf 9th absent", 32'(bus.busy), 32'd0);
        check("ovf empty", 32'(bus.empty), 32'd1);

        // Simultaneous push and pop at level 3.
        push(16'h0200, 8'hA0);
        push(16'h0201, 8'hA1);
        push(16'h0202, 8'hA2);
        check("pp level3", 32'(bus.level), 32'd3);
        check("pp in wait", 32'(bus.busy && !bus.wrVga), 32'd1);
        manual_req   = 1'b1;
        bus.hostWr   = 1'b1;
        bus.hostAddr = 16'h0203;
        bus.hostData = 8'hA3;
        tick();
        manual_req = 1'b0;
        bus.hostWr = 1'b0;
        check("pp level kept", 32'(bus.level), 32'd3);
        ack_expect("pp B", 16'h0201, 8'hA1);
        ack_expect("pp C", 16'h0202, 8'hA2);
        ack_expect("pp D", 16'h0203, 8'hA3);
        check("pp empty", 32'(bus.empty), 32'd1);

        // Drain order through the controller model.
        model_en = 1'b1;
        base = pulse_cnt;
        bus.hostWr = 1'b1;
        bus.hostAddr = 16'h0000; bus.hostData = 8'h11; tick();
        bus.hostAddr = 16'h0001; bus.hostData = 8'h22; tick();
        bus.hostAddr = 16'h00FF; bus.hostData = 8'h33; tick();
        bus.hostWr = 1'b0;
        repeat (21) tick();
        check("dr writes", 32'(wr_addr.size()), 32'd3);
        if (wr_addr.size() == 3) begin
            check("dr addr0", 32'(wr_addr[0]), 32'h0000);
            check("dr data0", 32'(wr_data[0]), 32'h11);
            check("dr addr1", 32'(wr_addr[1]), 32'h0001);
            check("dr data1", 32'(wr_data[1]), 32'h22);
            check("dr addr2", 32'(wr_addr[2]), 32'h00FF);
            check("dr data2", 32'(wr_data[2]), 32'h33);
        end
        check("dr pulses", 32'(pulse_cnt - base), 32'd3);
        check("dr stable", 32'(stab_err), 32'd0);
        check("dr empty", 32'(bus.empty), 32'd1);
        model_en = 1'b0;
        repeat (2) tick();

        // Reset while waiting with 4 entries queued.
        for (int i = 0; i < 4; i++) push(16'h0300 + 16'(i), 8'hC0 + 8'(i));
        repeat (3) tick();
        check("rw in wait", 32'(bus.busy && !bus.wrVga), 32'd1);
        #5 reset = 1'b1;
        #1;
        check("rw wrVga", 32'(bus.wrVga), 32'd0);
        check("rw aVga", 32'(bus.aVga), 32'd0);
        check("rw level", 32'(bus.level), 32'd0);
        check("rw empty", 32'(bus.empty), 32'd1);
        check("rw busy", 32'(bus.busy), 32'd0);
        tick();
        reset = 1'b0;
        base = pulse_cnt;
        repeat (10) tick();
        check("rw no pulses", 32'(pulse_cnt - base), 32'd0);
        check("rw still idle", 32'(bus.busy), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
